// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-side pointer and flag controller for the G16 FIFO family.
// Everything lives in the wr_clk domain; rd_ptr arrives already synchronised.
// The pointer is {wrap, idx} in binary, with idx running 0..DEPTH-1 so that
// non-power-of-two depths are supported.
// Optional feature macro: FIFO_WR_OVF_EN adds sticky overflow tracking and a
// saturating count of rejected writes. When it is undefined, o_overflow and
// ovf_count are tied to zero and no overflow state exists.
module fifo_wr_ctrl #(
    parameter int AW           = 8,
    parameter int DEPTH        = 150,
    parameter int AFULL_THRESH = DEPTH - 4,
    parameter int OVF_CNT_W    = 8
) (
    input  logic                 wr_clk,
    input  logic                 wr_rst,
    input  logic                 wr_en,
    input  logic [AW:0]          rd_ptr,
    output logic [AW:0]          wr_ptr,
    output logic [AW-1:0]        wr_addr,
    output logic                 wr_mem_en,
    output logic                 wr_ack,
    output logic                 o_fifo_full,
    output logic                 o_almost_full,
    output logic [AW:0]          wr_level,
    output logic                 o_overflow,
    output logic [OVF_CNT_W-1:0] ovf_count
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_L  = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   AFULL_L  = (AW + 1)'(AFULL_THRESH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic        wr_ack_q, wr_ack_d;
    logic        wrap_diff;
    logic        full;
    logic        accept;
    logic [AW:0] level;

    // Fill level and flags from the current write pointer and synchronised read pointer.
    // The subtraction wraps modulo 2**(AW+1), which gives the same low AW+1 bits
    // as computing one bit wider and truncating.
    always_comb begin
        wrap_diff = wr_ptr_q[AW] ^ rd_ptr[AW];
        level     = {1'b0, wr_ptr_q[AW-1:0]} - {1'b0, rd_ptr[AW-1:0]};
        if (wrap_diff) begin
            level = level + DEPTH_L;
        end
        full   = wrap_diff && (wr_ptr_q[AW-1:0] == rd_ptr[AW-1:0]);
        accept = wr_en && !full && !wr_rst;
    end

    // Next pointer: idx counts 0..DEPTH-1, and the wrap bit toggles when idx rolls over.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        wr_ack_d = accept;
        if (accept) begin
            if (wr_ptr_q[AW-1:0] == LAST_IDX) begin
                wr_ptr_d = {~wr_ptr_q[AW], {AW{1'b0}}};
            end else begin
                wr_ptr_d = {wr_ptr_q[AW], wr_ptr_q[AW-1:0] + 1'b1};
            end
        end
    end

    // Pointer and acknowledge registers; reset discards any in-flight write.
    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            wr_ptr_q <= '0;
            wr_ack_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            wr_ack_q <= wr_ack_d;
        end
    end

    assign wr_ptr        = wr_ptr_q;
    assign wr_addr       = wr_ptr_q[AW-1:0];
    assign wr_mem_en     = accept;
    assign wr_ack        = wr_ack_q;
    assign o_fifo_full   = full;
    assign o_almost_full = (level >= AFULL_L);
    assign wr_level      = level;

`ifdef FIFO_WR_OVF_EN
    typedef enum logic {
        OVF_IDLE = 1'b0,
        OVF_SEEN = 1'b1
    } ovf_state_e;

    ovf_state_e           ovf_state_q, ovf_state_d;
    logic [OVF_CNT_W-1:0] ovf_count_q, ovf_count_d;
    logic                 ovf_event;

    // A write attempted while full latches the sticky flag and bumps the saturating count.
    always_comb begin
        ovf_event   = wr_en && full && !wr_rst;
        ovf_state_d = ovf_state_q;
        ovf_count_d = ovf_count_q;
        if (ovf_event) begin
            ovf_state_d = OVF_SEEN;
            if (ovf_count_q != {OVF_CNT_W{1'b1}}) begin
                ovf_count_d = ovf_count_q + 1'b1;
            end
        end
    end

    // Overflow state registers; only reset clears them.
    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            ovf_state_q <= OVF_IDLE;
            ovf_count_q <= '0;
        end else begin
            ovf_state_q <= ovf_state_d;
            ovf_count_q <= ovf_count_d;
        end
    end

    assign o_overflow = (ovf_state_q == OVF_SEEN);
    assign ovf_count  = ovf_count_q;
`else
    assign o_overflow = 1'b0;
    assign ovf_count  = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Testbench for fifo_wr_ctrl (AW=8, DEPTH=150, AFULL_THRESH=146).
// The reference model tracks the write and read positions as plain integers
// in the range 0..2*DEPTH-1. The fill level is their modular difference.
module tb_fifo_wr_ctrl;

    localparam int AW    = 8;
    localparam int DEPTH = 150;
    localparam int AFULL = 146;
    localparam int OW    = 8;
    localparam int SPAN  = 2 * DEPTH;

    logic          wr_clk = 1'b0;
    logic          wr_rst;
    logic          wr_en;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   wr_ptr;
    logic [AW-1:0] wr_addr;
    logic          wr_mem_en;
    logic          wr_ack;
    logic          o_fifo_full;
    logic          o_almost_full;
    logic [AW:0]   wr_level;
    logic          o_overflow;
    logic [OW-1:0] ovf_count;

    int n_chk  = 0;
    int n_fail = 0;

    // model state
    int p;      // write position 0..SPAN-1
    int r;      // read position 0..SPAN-1
    int m_ack;
    int m_ovf;
    int m_cnt;

    fifo_wr_ctrl #(
        .AW(AW), .DEPTH(DEPTH), .AFULL_THRESH(AFULL), .OVF_CNT_W(OW)
    ) dut (
        .wr_clk(wr_clk), .wr_rst(wr_rst), .wr_en(wr_en), .rd_ptr(rd_ptr),
        .wr_ptr(wr_ptr), .wr_addr(wr_addr), .wr_mem_en(wr_mem_en), .wr_ack(wr_ack),
        .o_fifo_full(o_fifo_full), .o_almost_full(o_almost_full), .wr_level(wr_level),
        .o_overflow(o_overflow), .ovf_count(ovf_count)
    );

    always #5 wr_clk = ~wr_clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        rst;
        logic        we;
        logic [AW:0] rd;
        logic        chk;
        logic [AW:0] e_ptr;
        logic [AW:0] e_lvl;
        logic        e_mem;
        logic        e_ack;
        logic        e_full;
    } vec_t;

    vec_t tbl[9];

    function automatic logic [AW:0] pos2ptr(input int pos);
        logic [AW:0] v;
        v[AW]     = (pos >= DEPTH);
        v[AW-1:0] = AW'(pos % DEPTH);
        return v;
    endfunction

    function automatic int mlevel();
        return (p - r + SPAN) % SPAN;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input int we, input int rst);
        int lvl;
        lvl = mlevel();
        chk("legal_rd_idx", int'(int'(rd_ptr[AW-1:0]) < DEPTH), 1);
        chk("legal_level", int'(int'(wr_level) <= DEPTH), 1);
        chk("wr_ptr", int'(wr_ptr), int'(pos2ptr(p)));
        chk("wr_addr", int'(wr_addr), p % DEPTH);
        chk("wr_level", int'(wr_level), lvl);
        chk("full", int'(o_fifo_full), int'(lvl == DEPTH));
        chk("almost_full", int'(o_almost_full), int'(lvl >= AFULL));
        chk("wr_mem_en", int'(wr_mem_en), int'(we != 0 && rst == 0 && lvl != DEPTH));
        chk("wr_ack", int'(wr_ack), m_ack);
        chk("overflow", int'(o_overflow), m_ovf);
        chk("ovf_count", int'(ovf_count), m_cnt);
    endtask

    // One clock: drive inputs, check combinational and registered outputs, then advance the model.
    task automatic cycle(input int we, input int rst, input int rpos);
        int lvl;
        r      = rpos;
        wr_en  = (we != 0);
        wr_rst = (rst != 0);
        rd_ptr = pos2ptr(r);
        #1;
        check_all(we, rst);
        @(posedge wr_clk);
        lvl = mlevel();
        if (rst != 0) begin
            p = 0; m_ack = 0; m_ovf = 0; m_cnt = 0;
        end else begin
            m_ack = int'(we != 0 && lvl != DEPTH);
            if (m_ack != 0) p = (p + 1) % SPAN;
`ifdef FIFO_WR_OVF_EN
            if (we != 0 && lvl == DEPTH) begin
                m_ovf = 1;
                if (m_cnt < (1 << OW) - 1) m_cnt++;
            end
`endif
        end
        @(negedge wr_clk);
    endtask

    initial begin
        int exp_ovf_a;
        int exp_cnt_a;
        int nr;
        int rs;
        int we;
        int post_rst;
        int guard;

        //                 rst   we    rd      chk   ptr     lvl    mem   ack   full
        tbl[0] = '{1'b1, 1'b1, 9'h000, 1'b0, 9'h000, 9'd0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 9'h000, 1'b1, 9'h000, 9'd0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 9'h000, 1'b1, 9'h000, 9'd0, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 9'h000, 1'b1, 9'h001, 9'd1, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 9'h000, 1'b1, 9'h002, 9'd2, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 9'h000, 1'b1, 9'h002, 9'd2, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 9'h002, 1'b1, 9'h002, 9'd0, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 9'h002, 1'b1, 9'h003, 9'd1, 1'b0, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 9'h000, 1'b1, 9'h000, 9'd0, 1'b0, 1'b0, 1'b0};

`ifdef FIFO_WR_OVF_EN
        exp_ovf_a = 1;
`else
        exp_ovf_a = 0;
`endif

        wr_rst = 1'b1;
        wr_en  = 1'b0;
        rd_ptr = '0;
        @(negedge wr_clk);

        // reset, first writes, reads and a mid-burst reset from the vector table
        for (int i = 0; i < 9; i++) begin
            wr_rst = tbl[i].rst;
            wr_en  = tbl[i].we;
            rd_ptr = tbl[i].rd;
            #1;
            if (tbl[i].chk) begin
                chk("tbl_wr_ptr", int'(wr_ptr), int'(tbl[i].e_ptr));
                chk("tbl_wr_level", int'(wr_level), int'(tbl[i].e_lvl));
                chk("tbl_wr_mem_en", int'(wr_mem_en), int'(tbl[i].e_mem));
                chk("tbl_wr_ack", int'(wr_ack), int'(tbl[i].e_ack));
                chk("tbl_full", int'(o_fifo_full), int'(tbl[i].e_full));
            end
            @(posedge wr_clk);
            @(negedge wr_clk);
        end
        p = 0; r = 0; m_ack = 0; m_ovf = 0; m_cnt = 0;

        // fill from empty with the reader idle
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0);
        chk("fill_ptr", int'(wr_ptr), 'h100);
        chk("fill_full", int'(o_fifo_full), 1);
        chk("fill_level", int'(wr_level), DEPTH);
        chk("fill_afull", int'(o_almost_full), 1);

        // three writes against a full FIFO
        for (int i = 0; i < 3; i++) cycle(1, 0, 0);
        chk("ovf_ptr_hold", int'(wr_ptr), 'h100);
        chk("ovf_no_ack", int'(wr_ack), 0);
        chk("ovf_flag", int'(o_overflow), exp_ovf_a);
        chk("ovf_cnt3", int'(ovf_count), 3 * exp_ovf_a);

        // wrap: reader catches up at 0x100, write a full lap
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, DEPTH);
        chk("wrap_ptr0", int'(wr_ptr), 'h000);
        chk("wrap_full0", int'(o_fifo_full), 1);
        chk("wrap_level0", int'(wr_level), DEPTH);
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0);
        chk("wrap_ptr1", int'(wr_ptr), 'h100);
        chk("wrap_full1", int'(o_fifo_full), 1);

        // read pointer steps in the same cycle as a write against full
        cycle(1, 0, 0);
        cycle(1, 0, 1);
        chk("simul_ptr", int'(wr_ptr), 'h101);
        chk("simul_ack", int'(wr_ack), 1);

        // reset mid-burst at level 40, then resume from idx 0
        cycle(1, 1, (p - 40 + SPAN) % SPAN);
        chk("rst_ptr", int'(wr_ptr), 0);
        chk("rst_ovf", int'(o_overflow), 0);
        chk("rst_cnt", int'(ovf_count), 0);
        for (int i = 0; i < 5; i++) cycle(1, 0, 0);
        chk("resume_ptr", int'(wr_ptr), 5);

        // saturate the rejected-write count
        guard = 0;
        while (mlevel() != DEPTH && guard < SPAN) begin
            cycle(1, 0, 0);
            guard++;
        end
        chk("sat_fill_reached", int'(o_fifo_full), 1);
        for (int i = 0; i < 260; i++) cycle(1, 0, 0);
        exp_cnt_a = exp_ovf_a * 255;
        chk("sat_cnt", int'(ovf_count), exp_cnt_a);

        // randomized traffic against the model
        post_rst = 0;
        for (int i = 0; i < 2000; i++) begin
            rs = int'($urandom_range(0, 63) == 0);
            we = int'($urandom_range(0, 3) != 0);
            if (post_rst != 0) begin
                nr = 0;
            end else if ($urandom_range(0, 2) == 0) begin
                nr = (r + int'($urandom_range(0, mlevel()))) % SPAN;
            end else begin
                nr = r;
            end
            cycle(we, rs, nr);
            post_rst = rs;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
